// File: rtl/spi_slave_pkg.sv
// Shared constants for the SPI slave front end and the command FSM that sits behind it.
// Only SPI mode 0 is supported; CPOL/CPHA are kept here so both sides agree on it.
package spi_slave_pkg;

    localparam int WIDTH_DEFAULT = 8;

    localparam logic CPOL = 1'b0;
    localparam logic CPHA = 1'b0;

    // Opcodes understood by spi_fsm
    localparam logic [7:0] WRCMD = 8'h02;
    localparam logic [7:0] RDCMD = 8'h03;

    typedef enum logic [1:0] {
        TX_HOLD,
        TX_LOAD,
        TX_SHIFT
    } tx_action_e;

endpackage

// File: rtl/spi_slave_sync_edge.sv
// Two-flop synchroniser for an asynchronous pin, plus rise/fall pulses taken
// against a third (history) flop.
module sync_edge #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic meta;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta   <= RESET_VAL;
            sync_q <= RESET_VAL;
            prev_q <= RESET_VAL;
        end else begin
            meta   <= din;
            sync_q <= meta;
            prev_q <= sync_q;
        end
    end

    assign rise = sync_q & ~prev_q;
    assign fall = ~sync_q & prev_q;

endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 slave: oversamples sclk/cs_n/mosi on clk, deserialises MOSI into
// WIDTH-bit chunks and shifts a one-entry holding buffer out on MISO.
module spi_slave
    import spi_slave_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sclk,
    input  logic             cs_n,
    input  logic             mosi,
    output logic             miso,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_dv,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             wr,
    output logic             halt
);

    localparam int CW = $clog2(WIDTH);

    logic             sclk_rise;
    logic             sclk_fall;
    logic             cs_rise;
    logic             cs_fall;
    logic             mosi_meta;
    logic             mosi_sync;
    logic             selected;
    logic [CW-1:0]    bit_cnt;
    logic [WIDTH-2:0] rx_shift;
    logic [WIDTH-1:0] tx_shift;
    logic [WIDTH-1:0] tx_buf;
    tx_action_e       tx_action;

    sync_edge #(.RESET_VAL(CPOL)) u_sclk_edge (
        .clk  (clk),
        .rst  (rst),
        .din  (sclk),
        .rise (sclk_rise),
        .fall (sclk_fall)
    );

    sync_edge #(.RESET_VAL(1'b1)) u_cs_edge (
        .clk  (clk),
        .rst  (rst),
        .din  (cs_n),
        .rise (cs_rise),
        .fall (cs_fall)
    );

    // mosi gets the same two-flop delay as sclk so data stays aligned with its edge
    always_ff @(posedge clk) begin
        if (rst) begin
            mosi_meta <= 1'b0;
            mosi_sync <= 1'b0;
        end else begin
            mosi_meta <= mosi;
            mosi_sync <= mosi_meta;
        end
    end

    // rx_shift holds only the first WIDTH-1 bits; the last bit goes straight into rx_data
    always_ff @(posedge clk) begin
        if (rst) begin
            selected <= 1'b0;
            bit_cnt  <= '0;
            rx_shift <= '0;
            rx_data  <= '0;
            rx_dv    <= 1'b0;
        end else begin
            rx_dv <= 1'b0;
            if (cs_fall) begin
                selected <= 1'b1;
            end else if (cs_rise) begin
                selected <= 1'b0;
            end
            if (cs_rise || !selected) begin
                bit_cnt  <= '0;
                rx_shift <= '0;
            end else if (sclk_rise) begin
                rx_shift <= {rx_shift[WIDTH-3:0], mosi_sync};
                if (bit_cnt == CW'(WIDTH - 1)) begin
                    rx_data <= {rx_shift, mosi_sync};
                    rx_dv   <= 1'b1;
                    bit_cnt <= '0;
                end else begin
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end
        end
    end

    always_comb begin
        tx_action = TX_HOLD;
        if (cs_fall) begin
            tx_action = TX_LOAD;
        end else if (selected && !cs_rise && sclk_fall) begin
            tx_action = (bit_cnt == '0) ? TX_LOAD : TX_SHIFT;
        end
    end

    // A write in the same cycle as a load sees the old halt, so it is dropped
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_shift <= '0;
            tx_buf   <= '0;
            halt     <= 1'b0;
        end else begin
            case (tx_action)
                TX_LOAD: begin
                    tx_shift <= halt ? tx_buf : '0;
                    halt     <= 1'b0;
                end
                TX_SHIFT: tx_shift <= {tx_shift[WIDTH-2:0], 1'b0};
                default: ;
            endcase
            if (wr && !halt) begin
                tx_buf <= tx_data;
                halt   <= 1'b1;
            end
        end
    end

    assign miso = selected & tx_shift[WIDTH-1];

endmodule

// File: tb/tb_spi_slave.sv
// Self-checking bench for spi_slave: a bit-banged mode-0 master at 8x oversampling,
// checked against a byte-level model of the holding buffer and received data.
module tb_spi_slave;

    logic       clk;
    logic       rst;
    logic       sclk;
    logic       cs_n;
    logic       mosi;
    logic       miso;
    logic [7:0] rx_data;
    logic       rx_dv;
    logic [7:0] tx_data;
    logic       wr;
    logic       halt;

    int checks;
    int errors;

    // Byte-level model: one-entry buffer, consumed at every load point
    logic       buf_full;
    logic [7:0] buf_val;
    logic [7:0] exp_rx[$];
    logic [7:0] got_rx[$];
    logic [7:0] mosi_bytes[8];

    spi_slave #(.WIDTH(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .sclk    (sclk),
        .cs_n    (cs_n),
        .mosi    (mosi),
        .miso    (miso),
        .rx_data (rx_data),
        .rx_dv   (rx_dv),
        .tx_data (tx_data),
        .wr      (wr),
        .halt    (halt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rx_dv) got_rx.push_back(rx_data);
    end

    initial begin
        #10000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic modelTake(output logic [7:0] v);
        v = buf_full ? buf_val : 8'h00;
        buf_full = 1'b0;
    endtask

    task automatic applyStimulus(input logic [7:0] d, input int cycles);
        for (int c = 0; c < cycles; c++) begin
            wr = 1'b1;
            tx_data = d;
            if (!buf_full) begin
                buf_full = 1'b1;
                buf_val = d;
            end
            @(negedge clk);
        end
        wr = 1'b0;
    endtask

    task automatic spiByte(input logic [7:0] out, input int nbits, input bit do_wr,
                           input logic [7:0] wd, input bit do_rst, output logic [7:0] got);
        got = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            mosi = out[7-i];
            repeat (4) @(negedge clk);
            sclk = 1'b1;
            got[7-i] = miso;
            if (do_wr && i == 2) applyStimulus(wd, 1);
            if (do_rst && i == 4) begin
                checkOutput("halt_pre_rst", {31'd0, halt}, {31'd0, buf_full});
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                buf_full = 1'b0;
                checkOutput("rst_halt", {31'd0, halt}, {31'd0, buf_full});
                checkOutput("rst_rx_dv", {31'd0, rx_dv}, 32'd0);
                checkOutput("rst_miso", {31'd0, miso}, 32'd0);
                sclk = 1'b0;
                return;
            end
            repeat (4) @(negedge clk);
            sclk = 1'b0;
        end
    endtask

    task automatic spiTransaction(input int nbytes, input int last_bits, input int wr_byte,
                                  input logic [7:0] wr_data, input bit rst_mid);
        logic [7:0] exp_miso;
        logic [7:0] got;
        int nb;
        cs_n = 1'b0;
        modelTake(exp_miso);
        repeat (4) @(negedge clk);
        checkOutput("halt_after_csfall", {31'd0, halt}, {31'd0, buf_full});
        for (int k = 0; k < nbytes; k++) begin
            nb = (k == nbytes - 1) ? last_bits : 8;
            spiByte(mosi_bytes[k], nb, k == wr_byte, wr_data, rst_mid && (k == nbytes - 1), got);
            if (nb == 8) begin
                exp_rx.push_back(mosi_bytes[k]);
                checkOutput("miso_byte", {24'd0, got}, {24'd0, exp_miso});
                modelTake(exp_miso);
            end
        end
        repeat (4) @(negedge clk);
        cs_n = 1'b1;
        mosi = 1'b0;
        repeat (8) @(negedge clk);
        checkOutput("idle_miso", {31'd0, miso}, 32'd0);
        checkOutput("rx_count", got_rx.size(), exp_rx.size());
        while (exp_rx.size() > 0 && got_rx.size() > 0)
            checkOutput("rx_data", {24'd0, got_rx.pop_front()}, {24'd0, exp_rx.pop_front()});
        exp_rx.delete();
        got_rx.delete();
        checkOutput("halt_idle", {31'd0, halt}, {31'd0, buf_full});
    endtask

    initial begin
        int nbytes;
        int last_bits;
        int wr_byte;
        checks   = 0;
        errors   = 0;
        buf_full = 1'b0;
        buf_val  = 8'h00;
        rst = 1'b1; cs_n = 1'b1; sclk = 1'b0; mosi = 1'b0; wr = 1'b0; tx_data = 8'h00;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("reset_rx_dv", {31'd0, rx_dv}, 32'd0);
        checkOutput("reset_rx_data", {24'd0, rx_data}, 32'd0);
        checkOutput("reset_halt", {31'd0, halt}, 32'd0);
        checkOutput("reset_miso", {31'd0, miso}, 32'd0);

        // Plain receive with an empty buffer
        mosi_bytes[0] = 8'hA5;
        spiTransaction(1, 8, -1, 8'h00, 1'b0);

        // Single buffered byte
        applyStimulus(8'h3C, 1);
        @(negedge clk);
        checkOutput("halt_after_wr", {31'd0, halt}, 32'd1);
        mosi_bytes[0] = 8'h00;
        spiTransaction(1, 8, -1, 8'h00, 1'b0);

        // Back-to-back writes: second ignored until the next load
        applyStimulus(8'h11, 2);
        applyStimulus(8'h22, 1);
        @(negedge clk);
        checkOutput("halt_held", {31'd0, halt}, 32'd1);
        mosi_bytes[0] = 8'h03;
        mosi_bytes[1] = 8'hC3;
        spiTransaction(2, 8, 0, 8'h22, 1'b0);

        // Empty buffer over two bytes
        mosi_bytes[0] = 8'h5C;
        mosi_bytes[1] = 8'h3A;
        spiTransaction(2, 8, -1, 8'h00, 1'b0);

        // Aborted partial byte, then a full one
        mosi_bytes[0] = 8'hFF;
        spiTransaction(1, 5, -1, 8'h00, 1'b0);
        mosi_bytes[0] = 8'h81;
        spiTransaction(1, 8, -1, 8'h00, 1'b0);

        // Reset mid-byte while the buffer is full, then a clean transaction
        mosi_bytes[0] = 8'hF0;
        spiTransaction(1, 6, 0, 8'h77, 1'b1);
        mosi_bytes[0] = 8'h5A;
        spiTransaction(1, 8, -1, 8'h00, 1'b0);

        for (int t = 0; t < 30; t++) begin
            if ($urandom_range(0, 1) == 1) applyStimulus(8'($urandom), $urandom_range(1, 2));
            nbytes = $urandom_range(1, 3);
            for (int b = 0; b < nbytes; b++) mosi_bytes[b] = 8'($urandom);
            last_bits = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 8;
            wr_byte = ($urandom_range(0, 1) == 1) ? $urandom_range(0, nbytes - 1) : -1;
            spiTransaction(nbytes, last_bits, wr_byte, 8'($urandom), 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
